apb_master: RTL

APB initiator that turns single-beat commands from a local command port into APB transfers. It drives `psel`/`penable`/`pwrite`/`addr`/`pwdata` toward APB memory-style responders on the bus and returns read data or an error status on a response port. It sits between test or control logic and the 8-bit APB peripheral bus, with one transfer in flight at a time.

---
 rtl/apb_master.sv | 106 ++++++++++
 1 files changed

// File: rtl/apb_master.sv
// APB initiator: turns single-beat local commands into APB transfers.
// Only one transfer is in flight at a time. A transfer that stalls too long is aborted with rsp_err.
module apb_master #(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          busy,
  output logic          psel,
  output logic          penable,
  output logic          pwrite,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] pwdata,
  input  logic [DW-1:0] prdata,
  input  logic          pready
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] wait_nxt;

  // Saturating increment, so a disabled timeout can never wrap into a false abort
  assign wait_nxt  = (&wait_cnt) ? wait_cnt : wait_cnt + CW'(1);
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      addr      <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            pwrite   <= cmd_write;
            addr     <= cmd_addr;
            pwdata   <= cmd_wdata;
            wait_cnt <= '0;
            psel     <= 1'b1;
            penable  <= 1'b0;
            state    <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (pready) begin
            // Completion takes priority over a timeout landing in the same cycle
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= pwrite ? '0 : prdata;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_nxt;
            if ((TIMEOUT != 0) && (wait_nxt == TO_VAL)) begin
              psel      <= 1'b0;
              penable   <= 1'b0;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
              state     <= IDLE;
            end
          end
        end
        default: begin
          psel    <= 1'b0;
          penable <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
